// File: rtl/onchip_mem_stream_reader.sv
// onchip_mem_stream_reader
// Avalon-MM read master for a single-port on-chip RAM with a fixed 1-cycle
// read latency. Reads a word range (wrapping at MEM_WORDS) and emits it as an
// Avalon-ST packet. A small output FIFO with credit-based issue control
// ensures every returning word has a slot, even while the sink stalls.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start; no reads outstanding, FIFO empty
// S_ISSUE | issuing reads while words remain and FIFO credit allows
// S_DRAIN | all reads issued; waiting for the last return and FIFO drain

module onchip_mem_stream_reader #(
    parameter int MEM_WORDS  = 10240,
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 15,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [3:0]            mem_byteenable,
    output logic [DATA_WIDTH-1:0] mem_writedata,
    output logic                  mem_clken,
    input  logic [DATA_WIDTH-1:0] mem_readdata,
    output logic [DATA_WIDTH-1:0] src_data,
    output logic                  src_valid,
    input  logic                  src_ready,
    output logic                  src_startofpacket,
    output logic                  src_endofpacket
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] cur_q;
    logic [ADDR_WIDTH-1:0] cur_next;
    logic [LEN_WIDTH-1:0]  remaining_q;
    logic                  first_q;
    logic                  inflight_q;
    logic                  ret_sop_q;
    logic                  ret_eop_q;
    logic                  done_q;
    logic                  done_d;

    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic                  fifo_sop  [FIFO_DEPTH];
    logic                  fifo_eop  [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_next;
    logic [CW:0]           occupancy;

    logic accept_start;
    logic abort_act;
    logic credit_ok;
    logic issue;
    logic last_issue;
    logic push;
    logic pop;

    // Shared control terms used by both the FSM and the datapath
    always_comb begin
        accept_start = (state_q == S_IDLE) && start && !abort;
        abort_act    = (state_q != S_IDLE) && abort;
        // Occupancy counts words already buffered plus the one still in the RAM pipe
        occupancy    = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
        credit_ok    = occupancy < (CW + 1)'(FIFO_DEPTH);
        issue        = (state_q == S_ISSUE) && !abort && (remaining_q != '0) && credit_ok;
        last_issue   = issue && (remaining_q == LEN_WIDTH'(1));
        push         = inflight_q && !abort_act;
        pop          = (count_q != '0) && src_ready;
        count_next   = count_q + CW'(push) - CW'(pop);
        // RAM size is not a power of two, so wrap by explicit compare
        cur_next     = (cur_q == ADDR_WIDTH'(MEM_WORDS - 1)) ? '0 : cur_q + ADDR_WIDTH'(1);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state and completion decode
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept_start) begin
                    if (len != '0) begin
                        state_d = S_ISSUE;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (last_issue) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Look ahead one cycle so busy falls exactly when done pulses
                if (abort) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (count_next == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM outputs and stream view of the FIFO head
    always_comb begin
        busy              = (state_q != S_IDLE);
        done              = done_q;
        mem_chipselect    = issue;
        mem_address       = issue ? cur_q : '0;
        src_valid         = (count_q != '0);
        src_data          = src_valid ? fifo_data[rd_ptr_q] : '0;
        src_startofpacket = src_valid && fifo_sop[rd_ptr_q];
        src_endofpacket   = src_valid && fifo_eop[rd_ptr_q];
    end

    assign mem_write      = 1'b0;
    assign mem_byteenable = 4'hF;
    assign mem_writedata  = '0;
    assign mem_clken      = 1'b1;

    // Address/length tracking, read-return pipe tags and FIFO pointers
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_q       <= '0;
            remaining_q <= '0;
            first_q     <= 1'b0;
            inflight_q  <= 1'b0;
            ret_sop_q   <= 1'b0;
            ret_eop_q   <= 1'b0;
            done_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            done_q <= done_d;

            if (accept_start) begin
                cur_q       <= base;
                remaining_q <= len;
                first_q     <= 1'b1;
            end else if (issue) begin
                cur_q       <= cur_next;
                remaining_q <= remaining_q - LEN_WIDTH'(1);
                first_q     <= 1'b0;
            end

            // Packet markers travel alongside the read so they line up with its data
            inflight_q <= issue;
            ret_sop_q  <= issue && first_q;
            ret_eop_q  <= last_issue;

            if (abort_act) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PW'(1);
                end
                count_q <= count_next;
            end
        end
    end

    // FIFO storage; the credit rule means a push never lands on a live entry
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr_q] <= mem_readdata;
            fifo_sop[wr_ptr_q]  <= ret_sop_q;
            fifo_eop[wr_ptr_q]  <= ret_eop_q;
        end
    end

endmodule
